// File: rtl/fetch_queue.sv
// Instruction fetch front end: single-outstanding memory requester feeding a 2-entry {PC, instruction} queue.
// Latency: a response shows at the queue head the cycle after imem_rsp_valid; a redirect flushes the queue in one cycle.
// Backpressure: no request while occupancy + outstanding is 2; inst_ready low holds the head. Macro FETCH_STALL_CNT_EN builds stall_count.
module fetch_queue #(
    parameter int                      ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    next_PC_select,
    input  logic [ADDRESS_BITS-1:0] target_PC,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [ADDRESS_BITS-1:0] imem_addr,
    input  logic                    imem_rsp_valid,
    input  logic [31:0]             imem_rsp_data,
    output logic [ADDRESS_BITS-1:0] PC,
    output logic [31:0]             instruction,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [31:0]             stall_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [ADDRESS_BITS-1:0] pc;
        logic [31:0]             inst;
    } entry_t;

    typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

    state_t                  state;
    logic [ADDRESS_BITS-1:0] fetch_pc;
    logic [ADDRESS_BITS-1:0] pend_pc;
    entry_t                  q_mem [2];
    logic                    rd_ptr;
    logic                    wr_ptr;
    logic [1:0]              count;
    entry_t                  head;

    logic handoff;
    logic redirect;
    logic req_fire;
    logic push;
    logic pop;

    assign handoff  = inst_valid & inst_ready;
    assign redirect = handoff & next_PC_select;
    assign req_fire = imem_req_valid & imem_req_ready;
    // A response caught by a redirect in the same cycle belongs to the old path.
    assign push     = (state == WAIT) & imem_rsp_valid & ~redirect;
    assign pop      = handoff & ~redirect;

    // In REQ nothing is in flight, so queue occupancy alone decides whether a slot is free.
    assign imem_req_valid = ~reset & (state == REQ) & (count != 2'd2);
    assign imem_addr      = fetch_pc;

    assign head        = q_mem[rd_ptr];
    assign inst_valid  = (count != 2'd0);
    assign PC          = inst_valid ? head.pc : '0;
    assign instruction = inst_valid ? head.inst : NOP;

    // Request FSM and fetch address: one request in flight, redirect retargets fetch_pc.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
            pend_pc  <= RESET_PC;
        end else begin
            if (req_fire) begin
                pend_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= target_PC;
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + ADDRESS_BITS'(4);
            end
            case (state)
                REQ: begin
                    // A request accepted alongside a redirect is stale; its response must be dropped.
                    if (req_fire) begin
                        state <= redirect ? DROP : WAIT;
                    end
                end
                WAIT: begin
                    // A response arriving with the redirect closes the transaction, so no DROP is needed.
                    if (imem_rsp_valid) begin
                        state <= REQ;
                    end else if (redirect) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clock) begin
        if (reset || redirect) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Queue storage; contents are don't-care while their slot is unoccupied.
    always_ff @(posedge clock) begin
        if (push) begin
            q_mem[wr_ptr] <= '{pc: pend_pc, inst: imem_rsp_data};
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q;

    // Count cycles where decode wanted an instruction but the queue was empty; sticks at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (inst_ready && !inst_valid && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a single-outstanding instruction memory model of programmable latency.
// Inputs change one time unit after the rising edge; outputs are checked two units after it.
// Memory word at address a is 32'hA000_0000 | a, so every expected word below is written out by hand.
`timescale 1ns/1ps
module tb_fetch_queue;

    logic        clock;
    logic        reset;
    logic        next_PC_select;
    logic [15:0] target_PC;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [15:0] PC;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] stall_count;

`ifdef FETCH_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    int          n_chk;
    int          n_err;
    int          mem_lat;
    logic        mem_busy;
    int          mem_timer;
    logic [15:0] mem_addr;
    int          acc_count;
    int          acc_base;
    int          reqs_seen;

    fetch_queue dut (
        .clock          (clock),
        .reset          (reset),
        .next_PC_select (next_PC_select),
        .target_PC      (target_PC),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .PC             (PC),
        .instruction    (instruction),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .stall_count    (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return 32'hA000_0000 | {16'h0000, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: note any acceptance at the coming edge, then advance the memory model.
    task automatic tick();
        logic        acc;
        logic [15:0] a;
        @(negedge clock);
        acc = imem_req_valid && imem_req_ready;
        a   = imem_addr;
        @(posedge clock);
        #1;
        if (acc) begin
            mem_busy  = 1'b1;
            mem_timer = mem_lat;
            mem_addr  = a;
            acc_count++;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (mem_busy) begin
            mem_timer--;
            if (mem_timer == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_busy       = 1'b0;
            end
        end
        #1;
    endtask

    task automatic wait_head(input string tag, input int budget);
        for (int i = 0; i < budget && !inst_valid; i++) tick();
        chk(tag, {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic wait_req(input string tag, input int budget);
        for (int i = 0; i < budget && !imem_req_valid; i++) tick();
        chk(tag, {31'd0, imem_req_valid}, 32'd1);
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        mem_lat = 1; mem_busy = 1'b0; mem_timer = 0; mem_addr = 16'h0; acc_count = 0;
        reset = 1'b1; next_PC_select = 1'b0; target_PC = 16'h0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; inst_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_instruction", instruction, 32'h0000_0013);
        chk("rst_pc", {16'd0, PC}, 32'd0);
        chk("rst_stall", stall_count, 32'd0);

        // Streaming with ready=1, latency 1
        reset = 1'b0; inst_ready = 1'b1;
        #1;
        chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_req_addr", {16'd0, imem_addr}, 32'h0000);
        wait_head("head0_wait", 10);
        chk("head0_pc", {16'd0, PC}, 32'h0000);
        chk("head0_inst", instruction, 32'hA000_0000);
        tick();
        wait_head("head4_wait", 10);
        chk("head4_pc", {16'd0, PC}, 32'h0004);
        chk("head4_inst", instruction, 32'hA000_0004);
        tick();
        wait_head("head8_wait", 10);
        inst_ready = 1'b0; mem_lat = 3;
        chk("head8_pc", {16'd0, PC}, 32'h0008);
        chk("head8_inst", instruction, 32'hA000_0008);
        chk("reqC_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("reqC_addr", {16'd0, imem_addr}, 32'h000C);
        tick();
        chk("held8_pc", {16'd0, PC}, 32'h0008);
        chk("one_outstanding", {31'd0, imem_req_valid}, 32'd0);

        // Redirect to 0x0100 with 0x000C in flight; 0x000C must be dropped
        inst_ready = 1'b1; next_PC_select = 1'b1; target_PC = 16'h0100;
        tick();
        target_PC = 16'h0200;   // select still high but no handoff: ignored
        chk("redir_flush", {31'd0, inst_valid}, 32'd0);
        chk("redir_drop_noreq", {31'd0, imem_req_valid}, 32'd0);
        tick();
        next_PC_select = 1'b0;
        wait_req("redir_req_wait", 10);
        chk("redir_req_addr", {16'd0, imem_addr}, 32'h0100);
        wait_head("redir_head_wait", 10);
        chk("redir_head_pc", {16'd0, PC}, 32'h0100);
        chk("redir_head_inst", instruction, 32'hA000_0100);
        mem_lat = 1;
        tick();

        // Decode stalled for 10 cycles: queue fills to 2, requests stop
        inst_ready = 1'b0;
        reqs_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (i >= 5 && imem_req_valid) reqs_seen++;
            tick();
        end
        chk("full_no_req", reqs_seen, 32'd0);
        chk("full_req_valid", {31'd0, imem_req_valid}, 32'd0);
        inst_ready = 1'b1;
        chk("full_head_pc", {16'd0, PC}, 32'h0104);
        chk("full_head_inst", instruction, 32'hA000_0104);
        tick();
        chk("drain2_pc", {16'd0, PC}, 32'h0108);
        chk("drain2_inst", instruction, 32'hA000_0108);
        chk("drain2_req_addr", {16'd0, imem_addr}, 32'h010C);
        tick();
        chk("drain_exactly2", {31'd0, inst_valid}, 32'd0);

        // Redirect to 0xFFFC on the cycle 0x0110 is accepted, then wrap to 0x0000
        wait_head("wrap_head_wait", 10);
        chk("pre_wrap_pc", {16'd0, PC}, 32'h010C);
        next_PC_select = 1'b1; target_PC = 16'hFFFC;
        tick();
        next_PC_select = 1'b0;
        chk("wrap_flush", {31'd0, inst_valid}, 32'd0);
        chk("wrap_drop_noreq", {31'd0, imem_req_valid}, 32'd0);
        wait_req("wrap_req_wait", 10);
        chk("wrap_req_addr", {16'd0, imem_addr}, 32'hFFFC);
        wait_head("wrap_head_wait2", 10);
        chk("wrap_head_pc", {16'd0, PC}, 32'hFFFC);
        chk("wrap_head_inst", instruction, 32'hA000_FFFC);
        chk("wrap_next_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("wrap_next_addr", {16'd0, imem_addr}, 32'h0000);

        // Memory not ready for 3 cycles: address holds, single acceptance
        imem_req_ready = 1'b0;
        acc_base = acc_count;
        for (int i = 0; i < 3; i++) begin
            chk("nrdy_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("nrdy_addr", {16'd0, imem_addr}, 32'h0000);
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        chk("nrdy_one_accept", acc_count - acc_base, 32'd1);
        chk("nrdy_waiting", {31'd0, imem_req_valid}, 32'd0);
        wait_head("nrdy_head_wait", 10);
        chk("nrdy_head_pc", {16'd0, PC}, 32'h0000);
        chk("nrdy_head_inst", instruction, 32'hA000_0000);

        // Reset with 0x0004 in flight; its response lands in the first cycle after reset
        mem_lat = 3; inst_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("mrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("mrst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("mrst_instruction", instruction, 32'h0000_0013);
        chk("mrst_stall", stall_count, 32'd0);
        tick();
        reset = 1'b0; inst_ready = 1'b1; mem_lat = 4;
        #1;
        chk("mrst_stale_rsp", {31'd0, imem_rsp_valid}, 32'd1);
        chk("mrst_req_valid2", {31'd0, imem_req_valid}, 32'd1);
        chk("mrst_req_addr", {16'd0, imem_addr}, 32'h0000);

        // Latency 4 with ready=1: starvation cycles are counted when the counter is built
        wait_head("lat4_head0_wait", 10);
        chk("lat4_head0_pc", {16'd0, PC}, 32'h0000);
        chk("lat4_head0_inst", instruction, 32'hA000_0000);
        chk("stall_after5", stall_count, STALL_EN ? 32'd5 : 32'd0);
        tick();
        wait_head("lat4_head4_wait", 10);
        chk("lat4_head4_pc", {16'd0, PC}, 32'h0004);
        chk("lat4_head4_inst", instruction, 32'hA000_0004);
        chk("stall_after9", stall_count, STALL_EN ? 32'd9 : 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDRESS_BITS, default 16, width of every PC and address signal.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 The block SHALL use one clock, `clock`, and a synchronous, active-high reset, `reset`; all state SHALL change only on the rising edge of `clock`.
REQ-004 clock  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 next_PC_select  input  1  redirect request from decode, qualified by an instruction handoff.
REQ-007 target_PC  input  ADDRESS_BITS  redirect destination from decode.
REQ-008 imem_req_valid  output  1  instruction-memory request valid.
REQ-009 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-010 imem_addr  output  ADDRESS_BITS  request address.
REQ-011 imem_rsp_valid  input  1  response data valid.
REQ-012 imem_rsp_data  input  32  returned instruction word.
REQ-013 PC  output  ADDRESS_BITS  PC of the queue head.
REQ-014 instruction  output  32  instruction word at the queue head.
REQ-015 inst_valid  output  1  queue head valid.
REQ-016 inst_ready  input  1  decode consumes the head this cycle.
REQ-017 stall_count  output  32  count of cycles in which decode starved.

Function
REQ-018 The queue SHALL be a 2-entry FIFO of {PC, instruction}; a handoff SHALL occur when inst_valid and inst_ready are both high.
REQ-019 At most one memory request SHALL be outstanding.
REQ-020 A request SHALL be issued only when (queue occupancy + outstanding) < 2, so the queue can never overflow.
REQ-021 imem_addr SHALL stay stable while imem_req_valid is high and imem_req_ready is low.
REQ-022 On request acceptance, fetch_pc SHALL advance by 4 modulo 2^ADDRESS_BITS, wrapping from the top address to 0.
REQ-023 FSM states SHALL be REQ (presenting a request), WAIT (awaiting a response) and DROP (awaiting a response that will be discarded).
REQ-024 FSM transitions: REQ->WAIT on acceptance; WAIT->REQ on imem_rsp_valid; DROP->REQ on imem_rsp_valid, with the data discarded.
REQ-025 A response in WAIT SHALL be pushed at the queue tail; it SHALL be visible at the outputs no earlier than the cycle after imem_rsp_valid.
REQ-026 The next request SHALL be presented no earlier than the cycle after the response.
REQ-027 Redirect SHALL occur when next_PC_select is high during a handoff.
REQ-028 On redirect, the queue SHALL be flushed and fetch_pc SHALL be loaded with target_PC.
REQ-029 On redirect, if a request is outstanding or is accepted in the same cycle, the FSM SHALL go to DROP; otherwise it SHALL go to REQ.
REQ-030 If a redirect coincides with imem_rsp_valid, that response SHALL be discarded.
REQ-031 A simultaneous push and pop SHALL keep occupancy unchanged and preserve order.
REQ-032 next_PC_select without a handoff SHALL be ignored.
REQ-033 When the queue is empty: inst_valid=0, instruction=32'h00000013 (NOP), PC=0.

Reset
REQ-034 Reset SHALL set: fetch_pc=RESET_PC, FSM=REQ, queue empty, inst_valid=0, instruction=32'h00000013, PC=0, stall_count=0.
REQ-035 imem_req_valid SHALL be 0 during reset and SHALL go to 1 in the first cycle after reset deasserts.
REQ-036 Reset in mid-operation SHALL abandon any outstanding request; a response arriving in the first cycle after reset SHALL be ignored.

Configuration
REQ-037 Macro FETCH_STALL_CNT_EN: when defined, stall_count SHALL increment on every cycle with inst_ready=1 and inst_valid=0, saturating at 32'hFFFFFFFF.
REQ-038 When FETCH_STALL_CNT_EN is undefined, stall_count SHALL be tied to 0 and no counter logic SHALL be built.

Verification
REQ-039 Reset sequence, ready=1, 1-cycle memory latency, RESET_PC=0 -> handoffs with PC 0x0000, 0x0004, 0x0008 in order, with the correct words.
REQ-040 inst_ready=0 for 10 cycles -> exactly 2 entries queued, imem_req_valid=0 from then on, no data lost when inst_ready returns high.
REQ-041 Redirect to 0x0100 while a request to 0x000C is outstanding -> the 0x000C response is dropped, the next handoff has PC=0x0100.
REQ-042 fetch_pc=0xFFFC -> request issued at 0xFFFC, next request at 0x0000.
REQ-043 imem_req_ready held low 3 cycles -> imem_addr stable across all 3, single acceptance.
REQ-044 With FETCH_STALL_CNT_EN, memory latency 4, ready=1 -> stall_count increments on each empty-queue cycle; without the macro it stays 0.
